// File: rtl/mem36_parity_ctrl.sv
// rtl/mem36_parity_ctrl.sv - requester-side parity controller for a 36-bit zero-latency memory
//
// Purpose:
//   Accepts 32-bit byte-masked requests from a core and stores one even-parity
//   bit per byte in memory bits 35:32. Reads are parity-checked. Partial writes
//   become read-modify-write sequences, because the memory always writes the
//   parity nibble.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req_*                core request (valid/ready handshake)
//   rsp_valid/rdata/perr read response pulse, no backpressure
//   mem_*                memory request; mem_rdata valid the cycle after a read
//   err_count            parity error counter
//
// Optional feature:
//   MEM36_ERR_COUNT_EN   when defined, err_count counts response cycles that carry a
//                        parity error and saturates at 16'hFFFF; otherwise it is 0.

module mem36_parity_ctrl #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [3:0]       req_wmask,
  input  logic [31:0]      req_wdata,
  input  logic [WIDTH-1:0] req_addr,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic [3:0]       rsp_perr,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [3:0]       mem_wmask,
  output logic [35:0]      mem_wdata,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [35:0]      mem_rdata,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, RD_RSP, RMW} state_t;

  state_t           state;
  logic [WIDTH-1:0] lat_addr;
  logic [3:0]       lat_mask;
  logic [31:0]      lat_data;

  logic        accept;
  logic        full_mask;
  logic        part_mask;
  logic [31:0] merged_data;
  logic [3:0]  merged_par;
  logic [3:0]  lat_par;

  function automatic logic [3:0] byte_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign full_mask = &req_wmask;
  assign part_mask = (|req_wmask) & ~full_mask;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_addr <= '0;
      lat_mask <= '0;
      lat_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_write) begin
              state <= RD_RSP;
            end else if (part_mask) begin
              lat_addr <= req_addr;
              lat_mask <= req_wmask;
              lat_data <= req_wdata;
              state    <= RMW;
            end
          end
        end
        RD_RSP:  state <= IDLE;
        RMW:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Unwritten bytes keep their old parity bit so a pre-existing error in
  // them stays visible to later reads.
  assign lat_par = byte_par(lat_data);

  always_comb begin
    merged_data = '0;
    merged_par  = '0;
    for (int i = 0; i < 4; i++) begin
      merged_data[8*i +: 8] = lat_mask[i] ? lat_data[8*i +: 8] : mem_rdata[8*i +: 8];
      merged_par[i]         = lat_mask[i] ? lat_par[i] : mem_rdata[32+i];
    end
  end

  // Memory request is combinational; gating with rstn drops any in-flight
  // access the moment reset asserts.
  always_comb begin
    mem_valid = 1'b0;
    mem_write = 1'b0;
    mem_wmask = 4'h0;
    mem_wdata = 36'h0;
    mem_addr  = '0;
    if (rstn) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_write) begin
              mem_valid = 1'b1;
              mem_addr  = req_addr;
            end else if (full_mask) begin
              mem_valid = 1'b1;
              mem_write = 1'b1;
              mem_wmask = 4'hF;
              mem_wdata = {byte_par(req_wdata), req_wdata};
              mem_addr  = req_addr;
            end else if (part_mask) begin
              mem_valid = 1'b1;
              mem_addr  = req_addr;
            end
          end
        end
        RMW: begin
          mem_valid = 1'b1;
          mem_write = 1'b1;
          mem_wmask = 4'hF;
          mem_wdata = {merged_par, merged_data};
          mem_addr  = lat_addr;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RD_RSP);
  assign rsp_rdata = rsp_valid ? mem_rdata[31:0] : 32'h0;
  assign rsp_perr  = rsp_valid ? (byte_par(mem_rdata[31:0]) ^ mem_rdata[35:32]) : 4'h0;

`ifdef MEM36_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && (|rsp_perr) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0;
`endif

endmodule
